// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: shared rvc_asap types and constants, including end-of-test control
package rvc_asap_pkg;
    typedef enum logic [2:0] {RUN, RD, CAP, SEND, DONE} eot_state_t;
    typedef enum logic [1:0] {EOT_NONE, EOT_EBREAK, EOT_ECALL, EOT_TIMEOUT} eot_cause_t;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
endpackage

// File: rtl/rvc_asap_eot_watchdog.sv
// rvc_asap_eot_watchdog: run-phase cycle counter, Expired pulses on count LIMIT-1
module rvc_asap_eot_watchdog #(
    parameter logic [31:0] LIMIT = 32'd10_000_000
) (
    input  logic Clock,
    input  logic Rst,
    input  logic Enable,
    output logic Expired
);
    logic [31:0] count;
    always_ff @(posedge Clock) begin
        if (Rst) count <= '0;
        else if (Enable) count <= count + 32'd1;
    end
    assign Expired = Enable && count == LIMIT - 32'd1;
endmodule

// File: rtl/rvc_asap_eot_ctrl.sv
// rvc_asap_eot_ctrl: halt detection, core freeze and data-memory window dump over valid/ready.
// Optional watchdog end condition under RVC_ASAP_EOT_WATCHDOG_EN.
module rvc_asap_eot_ctrl
    import rvc_asap_pkg::*;
#(
    parameter int          NUM_HART    = 1,
    parameter bit          HALT_ALL    = 1'b1,
    parameter logic [31:0] DUMP_BASE   = 32'h1000,
    parameter int          DUMP_WORDS  = 1024,
    parameter logic [31:0] TIMEOUT_CYC = 32'd10_000_000
) (
    input  logic                     Clock,
    input  logic                     Rst,
    input  logic [NUM_HART-1:0]      InstValid,
    input  logic [NUM_HART*32-1:0]   InstructionQ101H,
    output logic                     HaltReq,
    output logic [NUM_HART-1:0]      HartHalted,
    output logic                     MemRdEn,
    output logic [31:0]              MemRdAddr,
    input  logic [31:0]              MemRdData,
    output logic                     DumpValid,
    input  logic                     DumpReady,
    output logic [31:0]              DumpAddr,
    output logic [31:0]              DumpData,
    output logic                     EotDone,
    output logic [1:0]               EotCause
);
    localparam int IW = $clog2(DUMP_WORDS + 1);

    if (DUMP_WORDS < 1) begin : g_bad_words
        $error("rvc_asap_eot_ctrl: DUMP_WORDS must be at least 1");
    end

    eot_state_t          state;
    eot_cause_t          cause_nxt;
    logic [IW-1:0]       idx;
    logic [NUM_HART-1:0] new_eb, new_ec, halted_nxt;
    logic                timeout, end_hit;

    // Already-halted harts are frozen, so their instruction bus is ignored.
    for (genvar h = 0; h < NUM_HART; h++) begin : g_hart
        assign new_eb[h] = InstValid[h] && !HartHalted[h] && InstructionQ101H[32*h +: 32] == EBREAK_INST;
        assign new_ec[h] = InstValid[h] && !HartHalted[h] && InstructionQ101H[32*h +: 32] == ECALL_INST;
    end

    assign halted_nxt = HartHalted | new_eb | new_ec;
    assign end_hit    = (HALT_ALL ? &halted_nxt : |halted_nxt) || timeout;
    assign cause_nxt  = |new_eb ? EOT_EBREAK : |new_ec ? EOT_ECALL : EOT_TIMEOUT;

`ifdef RVC_ASAP_EOT_WATCHDOG_EN
    rvc_asap_eot_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
        .Clock(Clock),
        .Rst(Rst),
        .Enable(state == RUN),
        .Expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state      <= RUN;
            idx        <= '0;
            HartHalted <= '0;
            HaltReq    <= 1'b0;
            MemRdEn    <= 1'b0;
            MemRdAddr  <= '0;
            DumpValid  <= 1'b0;
            DumpAddr   <= '0;
            DumpData   <= '0;
            EotDone    <= 1'b0;
            EotCause   <= EOT_NONE;
        end else begin
            case (state)
                RUN: begin
                    HartHalted <= halted_nxt;
                    if (end_hit) begin
                        state     <= RD;
                        HaltReq   <= 1'b1;
                        MemRdEn   <= 1'b1;
                        MemRdAddr <= DUMP_BASE;
                        EotCause  <= cause_nxt;
                    end
                end
                RD: begin
                    state   <= CAP;
                    MemRdEn <= 1'b0;
                end
                CAP: begin
                    state     <= SEND;
                    DumpData  <= MemRdData;
                    DumpAddr  <= MemRdAddr;
                    DumpValid <= 1'b1;
                end
                SEND: if (DumpReady) begin
                    DumpValid <= 1'b0;
                    if (idx == IW'(DUMP_WORDS - 1)) begin
                        state   <= DONE;
                        EotDone <= 1'b1;
                    end else begin
                        state     <= RD;
                        idx       <= idx + IW'(1);
                        MemRdEn   <= 1'b1;
                        MemRdAddr <= MemRdAddr + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/rvc_asap_eot_ctrl.md
# rvc_asap_eot_ctrl

- Synthesizable end-of-test controller for rvc_asap multi-hart builds.
- Watches each hart's decode-stage instruction for EBREAK/ECALL and, optionally, a watchdog timeout.
- Once the end condition is met, freezes the cores and sequentially reads a data-memory window through a dedicated read port.
- Streams the window out as address/data words over a valid/ready interface (FPGA/UART snapshot path). It sits beside the core(s), next to the memory wrapper, and replaces simulation-only snapshot logic.

## Interface
- NUM_HART, 1, number of monitored harts (1..8)
- HALT_ALL, 1, 1: end when every hart halted; 0: end on first halted hart
- DUMP_BASE, 32'h1000, byte address of first dumped word (4-byte aligned)
- DUMP_WORDS, 1024, words dumped (>=1, elaboration-time check)
- TIMEOUT_CYC, 32'd10_000_000, watchdog limit in cycles

- Clock  in  1  single clock
- Rst  in  1  synchronous, active-high reset
- InstValid  in  NUM_HART  per-hart InstructionQ101H valid
- InstructionQ101H  in  NUM_HART*32  per-hart decode instruction, hart h at [32h+31:32h]
- HaltReq  out  1  freeze request to cores/memory wrapper
- HartHalted  out  NUM_HART  sticky per-hart halt flags
- MemRdEn  out  1  data-memory read strobe
- MemRdAddr  out  32  data-memory byte address
- MemRdData  in  32  read data, valid the cycle after MemRdEn
- DumpValid  out  1  dump word available
- DumpReady  in  1  consumer accepts word
- DumpAddr  out  32  address of current dump word
- DumpData  out  32  current dump word
- EotDone  out  1  dump complete, sticky until reset
- EotCause  out  2  0 none, 1 EBREAK, 2 ECALL, 3 TIMEOUT

## Operation
- States: RUN, RD, CAP, SEND, DONE.
- RUN: a hart h sets HartHalted[h] when InstValid[h] and the instruction equals 32'h00100073 (EBREAK) or 32'h00000073 (ECALL). Once a hart is halted, its later instructions are ignored.
- End condition: (HALT_ALL ? &HartHalted : |HartHalted), or watchdog expiry. RUN->RD, HaltReq=1, EotCause latched.
- Cause priority in the same cycle: EBREAK > ECALL > TIMEOUT. With mixed causes across harts, the cause of the triggering cycle is recorded.
- RD: MemRdEn=1, MemRdAddr=DumpBase+4*idx. Always ->CAP.
- CAP: DumpData<=MemRdData, DumpAddr<=MemRdAddr. ->SEND.
- SEND: DumpValid=1. DumpData/DumpAddr stay stable until DumpValid&&DumpReady.
  - On handshake, if idx==DUMP_WORDS-1 ->DONE.
  - Otherwise idx++ and ->RD.
- DONE: EotDone=1, HaltReq=1, all other outputs idle. Only Rst leaves DONE.
- idx width: $clog2(DUMP_WORDS+1). The address adds in 32 bits and wraps modulo 2^32.

## Timing
- Reset values: HaltReq 0, HartHalted 0, MemRdEn 0, MemRdAddr 0, DumpValid 0, DumpAddr 0, DumpData 0, EotDone 0, EotCause 0. State RUN, idx 0, watchdog 0.
- Halting instruction in cycle N:
  - HartHalted bit set at N+1.
  - If it completes the end condition: HaltReq and MemRdEn high at N+1, DumpValid high at N+3.
- Per-word minimum period: 3 cycles with DumpReady tied high.
- Full dump: 3*DUMP_WORDS cycles from the first RD to DONE when not back-pressured.
- Rst asserted in any state (including mid-dump): all state clears on the next edge, and the dump is not resumed.
- Watchdog and final halt in the same cycle: the halt cause wins.

## Configuration
- RVC_ASAP_EOT_WATCHDOG_EN defined:
  - a cycle counter runs in RUN from reset release;
  - reaching TIMEOUT_CYC-1 ends the test with EotCause=3.
- Undefined: no counter is built and only EBREAK/ECALL end the test. TIMEOUT_CYC is ignored.

## Structure
- rvc_asap_pkg gains:
  - eot_state_t (RUN, RD, CAP, SEND, DONE);
  - eot_cause_t (EOT_NONE, EOT_EBREAK, EOT_ECALL, EOT_TIMEOUT);
  - constants EBREAK_INST=32'h00100073 and ECALL_INST=32'h00000073.
- Sub-module rvc_asap_eot_watchdog (counter plus expiry pulse) is instantiated only under RVC_ASAP_EOT_WATCHDOG_EN.

## Test plan
- NUM_HART=1, EBREAK at cycle 20 -> HartHalted=1 at 21, MemRdAddr=32'h1000 at 21, EotCause=1. With DUMP_WORDS=4 and DumpReady=1, addresses 0x1000..0x100C stream out and EotDone rises at 33.
- NUM_HART=2, HALT_ALL=1: hart0 ECALL at 10, hart1 EBREAK at 30 -> HaltReq stays low until 31, then EotCause=1.
- HALT_ALL=0, both harts halt in the same cycle with ECALL/EBREAK -> EotCause=1.
- DumpReady held low 5 cycles in SEND -> DumpData/DumpAddr unchanged, no extra MemRdEn, and word accepted exactly once.
- Rst pulsed while in SEND on word 2 -> all outputs return to reset values the next cycle, and a new EBREAK restarts from 32'h1000.
- With RVC_ASAP_EOT_WATCHDOG_EN and TIMEOUT_CYC=100, no halt -> HaltReq at cycle 100 after reset release, EotCause=3. Without the macro -> no halt.
